// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: EX-stage <-> multiply/divide unit bus.
//
// Handshake: the EX stage asserts MDU_start with a valid MDU_Op/MDU_A/MDU_B
// for one cycle. A mul/div is taken only when the unit is idle and MDU_flush is
// low. isbusy is combinational and already high in that start cycle, so a
// dependent HI/LO reader stalls at once. isbusy stays high until HI/LO have been
// written. MDU_done pulses for the one cycle after that write. MTHI/MTLO never
// raise isbusy. The stall logic must keep MDU_start low while isbusy is high
// for an earlier op.
//
// Signals
//   MDU_start  master->slave  EX instruction is an MDU op
//   MDU_Op     master->slave  000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                             100 MTHI, 101 MTLO, 11x no-op
//   MDU_A      master->slave  rs operand (dividend / multiplicand / MTxx data)
//   MDU_B      master->slave  rt operand (divisor / multiplier)
//   MDU_flush  master->slave  exception / eret flush, aborts the current op
//   isbusy     slave->master  unit occupied, feeds stall
//   MDU_done   slave->master  one-cycle pulse after a mul/div wrote HI/LO
//   HI, LO     slave->master  registered result pair
interface mdu_ctrl_if;
   logic        MDU_start;
   logic [2:0]  MDU_Op;
   logic [31:0] MDU_A;
   logic [31:0] MDU_B;
   logic        MDU_flush;
   logic        isbusy;
   logic        MDU_done;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (
      output MDU_start, MDU_Op, MDU_A, MDU_B, MDU_flush,
      input  isbusy, MDU_done, HI, LO
   );

   modport slave (
      input  MDU_start, MDU_Op, MDU_A, MDU_B, MDU_flush,
      output isbusy, MDU_done, HI, LO
   );
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: sequencer and HI/LO holder for the multiply/divide unit.
// Runs MULT/MULTU as 32-step shift-add and DIV/DIVU as 32-step restoring
// division on magnitudes. A final FIX cycle applies the sign correction and
// writes HI/LO. MTHI/MTLO write HI/LO directly from IDLE.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   bus      slave modport of mdu_ctrl_if (start/op/operands/flush in,
//            isbusy/MDU_done/HI/LO out)
//   o_state  out  FSM state for debug (0 IDLE, 1 CALC, 2 FIX)
module mdu_ctrl (
   input  logic       clk,
   input  logic       rst,
   mdu_ctrl_if.slave  bus,
   output logic [1:0] o_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next;

   logic [4:0]  r_cnt;
   logic [63:0] r_acc;     // mul: {partial product, multiplier}; div: {rem, quot}
   logic [31:0] r_opnd;    // mul: |multiplicand|; div: |divisor|
   logic [31:0] r_a_raw;   // original A, returned in HI on divide by zero
   logic        r_is_div;
   logic        r_neg_res;
   logic        r_neg_rem;
   logic        r_div0;
   logic        r_done;
   logic [31:0] r_hi;
   logic [31:0] r_lo;

   // Decode of the EX-stage request
   logic        w_is_muldiv;
   logic        w_is_mt;
   logic        w_signed;
   logic        w_a_neg;
   logic        w_b_neg;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;

   assign w_is_muldiv = bus.MDU_start & ~bus.MDU_Op[2];
   assign w_is_mt     = bus.MDU_start & bus.MDU_Op[2] & ~bus.MDU_Op[1];
   assign w_signed    = ~bus.MDU_Op[0];
   assign w_a_neg     = w_signed & bus.MDU_A[31];
   assign w_b_neg     = w_signed & bus.MDU_B[31];
   assign w_a_mag     = w_a_neg ? (~bus.MDU_A + 32'd1) : bus.MDU_A;
   assign w_b_mag     = w_b_neg ? (~bus.MDU_B + 32'd1) : bus.MDU_B;

   // Multiply step: conditional add into the upper half with carry out,
   // then shift the whole 65-bit value right by one.
   logic [32:0] w_mul_sum;
   logic [63:0] w_mul_next;

   assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
   assign w_mul_next = {w_mul_sum, r_acc[31:1]};

   // Divide step: after the left shift the partial remainder can need 33 bits,
   // so the trial subtract is done at 33 bits and bit 32 is the borrow.
   logic [32:0] w_div_up;
   logic [32:0] w_div_diff;
   logic [63:0] w_div_next;

   assign w_div_up   = r_acc[63:31];
   assign w_div_diff = w_div_up - {1'b0, r_opnd};
   assign w_div_next = w_div_diff[32] ? {w_div_up[31:0], r_acc[30:0], 1'b0}
                                      : {w_div_diff[31:0], r_acc[30:0], 1'b1};

   // Sign correction applied in FIX
   logic [63:0] w_prod_fix;
   logic [31:0] w_quot_fix;
   logic [31:0] w_rem_fix;

   assign w_prod_fix = r_neg_res ? (~r_acc + 64'd1) : r_acc;
   assign w_quot_fix = r_neg_res ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
   assign w_rem_fix  = r_neg_rem ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // FSM next state; a flush wins over every transition
   always_comb begin
      w_next = r_state;
      if (bus.MDU_flush) begin
         w_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: if (w_is_muldiv) w_next = ST_CALC;
            ST_CALC: if (r_cnt == 5'd31) w_next = ST_FIX;
            ST_FIX:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
         endcase
      end
   end

   // Datapath and HI/LO
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt     <= 5'd0;
         r_acc     <= 64'd0;
         r_opnd    <= 32'd0;
         r_a_raw   <= 32'd0;
         r_is_div  <= 1'b0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_div0    <= 1'b0;
         r_done    <= 1'b0;
         r_hi      <= 32'd0;
         r_lo      <= 32'd0;
      end else begin
         r_done <= 1'b0;
         if (!bus.MDU_flush) begin
            case (r_state)
               ST_IDLE: begin
                  if (w_is_muldiv) begin
                     r_is_div  <= bus.MDU_Op[1];
                     r_neg_res <= w_a_neg ^ w_b_neg;
                     r_neg_rem <= w_a_neg & bus.MDU_Op[1];
                     r_div0    <= bus.MDU_Op[1] & (bus.MDU_B == 32'd0);
                     r_a_raw   <= bus.MDU_A;
                     r_cnt     <= 5'd0;
                     // Divide iterates on the dividend, multiply on the multiplier
                     r_acc     <= bus.MDU_Op[1] ? {32'd0, w_a_mag} : {32'd0, w_b_mag};
                     r_opnd    <= bus.MDU_Op[1] ? w_b_mag : w_a_mag;
                  end else if (w_is_mt) begin
                     if (bus.MDU_Op[0]) r_lo <= bus.MDU_A;
                     else               r_hi <= bus.MDU_A;
                  end
               end
               ST_CALC: begin
                  r_acc <= r_is_div ? w_div_next : w_mul_next;
                  if (r_cnt != 5'd31) r_cnt <= r_cnt + 5'd1;
               end
               ST_FIX: begin
                  r_done <= 1'b1;
                  if (!r_is_div) begin
                     r_hi <= w_prod_fix[63:32];
                     r_lo <= w_prod_fix[31:0];
                  end else if (r_div0) begin
                     r_hi <= r_a_raw;
                     r_lo <= 32'hFFFF_FFFF;
                  end else begin
                     r_hi <= w_rem_fix;
                     r_lo <= w_quot_fix;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.isbusy   = ((r_state == ST_IDLE) & w_is_muldiv) | (r_state != ST_IDLE);
   assign bus.MDU_done = r_done;
   assign bus.HI       = r_hi;
   assign bus.LO       = r_lo;
   assign o_state      = r_state;

endmodule
